// File: rtl/dsp_pkg.sv
// -----------------------------------------------------------------------------
// dsp_pkg
// Shared constants for the DSP48A1 post-adder/accumulator slice model:
// datapath widths, OPMODE field encodings and bit positions, and the
// CARRYINSEL selector values.
// -----------------------------------------------------------------------------
package dsp_pkg;

  // Datapath widths
  localparam int P_W = 48;        // P / C / PCIN / DAB width
  localparam int M_W = 36;        // multiplier product width
  localparam int R_W = P_W + 1;   // post-adder result incl. carry/borrow bit

  // X mux select codes (opmode[1:0])
  localparam logic [1:0] X_ZERO = 2'd0;
  localparam logic [1:0] X_M    = 2'd1;
  localparam logic [1:0] X_P    = 2'd2;
  localparam logic [1:0] X_DAB  = 2'd3;

  // Z mux select codes (opmode[3:2])
  localparam logic [1:0] Z_ZERO = 2'd0;
  localparam logic [1:0] Z_PCIN = 2'd1;
  localparam logic [1:0] Z_P    = 2'd2;
  localparam logic [1:0] Z_C    = 2'd3;

  // OPMODE bit positions
  localparam int OPM_CIN = 5;
  localparam int OPM_SUB = 7;

  // CARRYINSEL selector values (7-character strings, 56 bits)
  localparam logic [55:0] CIS_OPMODE5 = "OPMODE5";
  localparam logic [55:0] CIS_CARRYIN = "CARRYIN";

endpackage

// File: rtl/dsp_post_adder_acc_chk.sv
// -----------------------------------------------------------------------------
// dsp_post_adder_acc_chk
// Simulation checks for the post-adder stage. Flags use of the P feedback
// selects when the P register is disabled (those selects read as zero in
// that configuration) and an unknown effective opmode.
// Ports:
//   clk       in  clock
//   rst       in  synchronous reset (checks disabled while asserted)
//   opmode_q  in  8  effective opmode seen by the muxes
// -----------------------------------------------------------------------------
module dsp_post_adder_acc_chk
  import dsp_pkg::*;
#(
  parameter int PREG = 1
) (
  input logic       clk,
  input logic       rst,
  input logic [7:0] opmode_q
);

  a_no_p_feedback_without_preg: assert property (
    @(posedge clk) disable iff (rst)
      (PREG != 0) || ((opmode_q[1:0] != X_P) && (opmode_q[3:2] != Z_P))
  );

  a_opmode_known: assert property (
    @(posedge clk) disable iff (rst)
      !$isunknown(opmode_q)
  );

endmodule

// File: rtl/dsp_sync_reg.sv
// -----------------------------------------------------------------------------
// dsp_sync_reg
// Generic pipeline register with clock enable and synchronous active-high
// reset. With BYPASS=1 the output follows d directly (register unused).
// Ports:
//   clk  in  clock
//   rst  in  synchronous reset, overrides ce
//   ce   in  clock enable
//   d    in  WIDTH data in
//   q    out WIDTH data out (registered, or d when bypassed)
// -----------------------------------------------------------------------------
module dsp_sync_reg #(
  parameter int WIDTH  = 1,
  parameter bit BYPASS = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ce,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] q_q;

  // Storage register: reset wins over enable
  always_ff @(posedge clk) begin
    if (rst) begin
      q_q <= {WIDTH{1'b0}};
    end else if (ce) begin
      q_q <= d;
    end else begin
      q_q <= q_q;
    end
  end

  // Output select: registered value or pass-through
  always_comb begin
    if (BYPASS) begin
      q = d;
    end else begin
      q = q_q;
    end
  end

endmodule

// File: rtl/dsp_post_adder_acc.sv
// -----------------------------------------------------------------------------
// dsp_post_adder_acc
// Post-adder/subtracter and accumulator stage of the DSP48A1 slice model.
// X and Z operands are chosen by opmode, combined with carry-in as a 49-bit
// unsigned add or subtract, and held in the P register (bit 48 = carryout).
// Ports:
//   clk        in   clock
//   rst        in   synchronous active-high reset of all registers
//   cep        in   enable for P/carryout register
//   ceopmode   in   enable for opmode register
//   cecarryin  in   enable for carry-in (CYI) register
//   m          in   36  multiplier product
//   dab        in   48  {D[11:0],A[17:0],B[17:0]}
//   c          in   48  C operand
//   pcin       in   48  cascade input
//   opmode     in   8   [1:0] X sel, [3:2] Z sel, [5] cin, [7] subtract
//   carryin    in   external carry-in (CARRYINSEL="CARRYIN")
//   p          out  48  result
//   pcout      out  48  cascade output, identical to p
//   carryout   out  carry (add) / borrow (subtract) from bit 48
// -----------------------------------------------------------------------------
module dsp_post_adder_acc
  import dsp_pkg::*;
#(
  parameter int          PREG       = 1,
  parameter int          OPMODEREG  = 1,
  parameter int          CARRYINREG = 1,
  parameter logic [55:0] CARRYINSEL = CIS_OPMODE5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            cep,
  input  logic            ceopmode,
  input  logic            cecarryin,
  input  logic [M_W-1:0]  m,
  input  logic [P_W-1:0]  dab,
  input  logic [P_W-1:0]  c,
  input  logic [P_W-1:0]  pcin,
  input  logic [7:0]      opmode,
  input  logic            carryin,
  output logic [P_W-1:0]  p,
  output logic [P_W-1:0]  pcout,
  output logic            carryout
);

  logic [7:0]     opmode_q;
  logic           cin_raw_s;
  logic           cyi_q;
  logic [P_W-1:0] p_fb_s;
  logic [P_W-1:0] x_s;
  logic [P_W-1:0] z_s;
  logic [R_W-1:0] pr_d;
  logic [R_W-1:0] pr_q;

  // Opmode register (or pass-through when OPMODEREG=0)
  dsp_sync_reg #(
    .WIDTH  (8),
    .BYPASS (OPMODEREG == 0)
  ) u_opmode_reg (
    .clk (clk),
    .rst (rst),
    .ce  (ceopmode),
    .d   (opmode),
    .q   (opmode_q)
  );

  // Carry-in source comes from the raw inputs so it lines up with the opmode register
  always_comb begin
    if (CARRYINSEL == CIS_CARRYIN) begin
      cin_raw_s = carryin;
    end else begin
      cin_raw_s = opmode[OPM_CIN];
    end
  end

  // CYI register (or pass-through when CARRYINREG=0)
  dsp_sync_reg #(
    .WIDTH  (1),
    .BYPASS (CARRYINREG == 0)
  ) u_cyi_reg (
    .clk (clk),
    .rst (rst),
    .ce  (cecarryin),
    .d   (cin_raw_s),
    .q   (cyi_q)
  );

  // P feedback reads as zero without a P register to break the combinational loop
  always_comb begin
    if (PREG != 0) begin
      p_fb_s = pr_q[P_W-1:0];
    end else begin
      p_fb_s = {P_W{1'b0}};
    end
  end

  // X operand mux; the product is zero-extended
  always_comb begin
    x_s = {P_W{1'b0}};
    case (opmode_q[1:0])
      X_ZERO:  x_s = {P_W{1'b0}};
      X_M:     x_s = {12'd0, m};
      X_P:     x_s = p_fb_s;
      X_DAB:   x_s = dab;
      default: x_s = {P_W{1'b0}};
    endcase
  end

  // Z operand mux
  always_comb begin
    z_s = {P_W{1'b0}};
    case (opmode_q[3:2])
      Z_ZERO:  z_s = {P_W{1'b0}};
      Z_PCIN:  z_s = pcin;
      Z_P:     z_s = p_fb_s;
      Z_C:     z_s = c;
      default: z_s = {P_W{1'b0}};
    endcase
  end

  // 49-bit post-adder: carry-in joins X, so subtract takes Z - (X + cin) and bit 48 is the borrow
  always_comb begin
    pr_d = {R_W{1'b0}};
    if (opmode_q[OPM_SUB]) begin
      pr_d = {1'b0, z_s} - ({1'b0, x_s} + {{P_W{1'b0}}, cyi_q});
    end else begin
      pr_d = {1'b0, z_s} + {1'b0, x_s} + {{P_W{1'b0}}, cyi_q};
    end
  end

  // P register holding {carryout, P}
  dsp_sync_reg #(
    .WIDTH  (R_W),
    .BYPASS (PREG == 0)
  ) u_p_reg (
    .clk (clk),
    .rst (rst),
    .ce  (cep),
    .d   (pr_d),
    .q   (pr_q)
  );

  assign p        = pr_q[P_W-1:0];
  assign pcout    = pr_q[P_W-1:0];
  assign carryout = pr_q[P_W];

  dsp_post_adder_acc_chk #(
    .PREG (PREG)
  ) u_chk (
    .clk      (clk),
    .rst      (rst),
    .opmode_q (opmode_q)
  );

endmodule

// File: tb/tb_dsp_post_adder_acc.sv
// -----------------------------------------------------------------------------
// tb_dsp_post_adder_acc
// Self-checking bench for dsp_post_adder_acc. Two instances share stimulus:
// dut0 takes carry-in from opmode[5], dut1 from the carryin port.
// -----------------------------------------------------------------------------
module tb_dsp_post_adder_acc;
  import dsp_pkg::*;

  logic        clk = 1'b0;
  logic        rst, cep, ceopmode, cecarryin, carryin;
  logic [35:0] m;
  logic [47:0] dab, c, pcin;
  logic [7:0]  opmode;
  logic [47:0] p0, pc0, p1, pc1;
  logic        co0, co1;

  int total = 0;
  int bad   = 0;

  // Reference state: shared opmode register, per-instance carry/P state
  logic [7:0]  opm_m;
  logic        cyi_m [2];
  logic [47:0] p_m   [2];
  logic        co_m  [2];

  always #5 clk = ~clk;

  dsp_post_adder_acc dut0 (
    .clk(clk), .rst(rst), .cep(cep), .ceopmode(ceopmode), .cecarryin(cecarryin),
    .m(m), .dab(dab), .c(c), .pcin(pcin), .opmode(opmode), .carryin(carryin),
    .p(p0), .pcout(pc0), .carryout(co0)
  );

  dsp_post_adder_acc #(.CARRYINSEL(CIS_CARRYIN)) dut1 (
    .clk(clk), .rst(rst), .cep(cep), .ceopmode(ceopmode), .cecarryin(cecarryin),
    .m(m), .dab(dab), .c(c), .pcin(pcin), .opmode(opmode), .carryin(carryin),
    .p(p1), .pcout(pc1), .carryout(co1)
  );

  // Arithmetic straight from the operand rules: 49-bit unsigned add or subtract
  function automatic logic [48:0] post_add(input logic [7:0] op, input logic cin,
                                           input logic [35:0] mv, input logic [47:0] dabv,
                                           input logic [47:0] cv, input logic [47:0] pcinv,
                                           input logic [47:0] pv);
    logic [48:0] x, z, ci;
    ci = {48'd0, cin};
    case (op[1:0])
      2'd0: x = 49'd0;
      2'd1: x = {13'd0, mv};
      2'd2: x = {1'b0, pv};
      default: x = {1'b0, dabv};
    endcase
    case (op[3:2])
      2'd0: z = 49'd0;
      2'd1: z = {1'b0, pcinv};
      2'd2: z = {1'b0, pv};
      default: z = {1'b0, cv};
    endcase
    if (op[7]) return z - (x + ci);
    else       return z + x + ci;
  endfunction

  // Advance one clock edge and step the reference model with the inputs seen at that edge
  task automatic tick();
    @(posedge clk);
    if (rst) begin
      opm_m = 8'd0;
      for (int k = 0; k < 2; k++) begin
        cyi_m[k] = 1'b0; p_m[k] = 48'd0; co_m[k] = 1'b0;
      end
    end else begin
      for (int k = 0; k < 2; k++)
        if (cep) {co_m[k], p_m[k]} = post_add(opm_m, cyi_m[k], m, dab, c, pcin, p_m[k]);
      if (cecarryin) begin
        cyi_m[0] = opmode[5];
        cyi_m[1] = carryin;
      end
      if (ceopmode) opm_m = opmode;
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; cep = 1'b1; ceopmode = 1'b1; cecarryin = 1'b1; carryin = 1'b0;
    m = 36'd0; dab = 48'd0; c = 48'd0; pcin = 48'd0; opmode = 8'h00;
    tick(); tick();
    total++;
    if (p0 !== 48'd0 || co0 !== 1'b0 || p1 !== 48'd0 || co1 !== 1'b0) begin
      bad++; $display("FAIL reset_init: got p0=%h co0=%b p1=%h co1=%b, expected 0", p0, co0, p1, co1);
    end
    rst = 1'b0; opmode = 8'h03; dab = 48'h123;
    tick(); tick();
    total++;
    if (p0 !== 48'h123) begin
      bad++; $display("FAIL reset_load: got p=%h, expected 000000000123", p0);
    end
    rst = 1'b1; cep = 1'b0;
    tick();
    total++;
    if (p0 !== 48'd0 || co0 !== 1'b0 || pc0 !== 48'd0) begin
      bad++; $display("FAIL reset_cep0: got p=%h co=%b pcout=%h, expected 0", p0, co0, pc0);
    end
    rst = 1'b0; cep = 1'b1; dab = 48'd0; opmode = 8'h00;
  endtask

  task automatic test_mac();
    rst = 1'b1; tick();
    rst = 1'b0; opmode = 8'h09; m = 36'd5;
    tick();
    for (int i = 1; i <= 4; i++) begin
      tick();
      total++;
      if (p0 !== 48'(5 * i) || p1 !== 48'(5 * i) || co0 !== 1'b0) begin
        bad++; $display("FAIL mac_step%0d: got p0=%h p1=%h co=%b, expected p=%h co=0",
                        i, p0, p1, co0, 48'(5 * i));
      end
    end
  endtask

  task automatic test_enables();
    cep = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      total++;
      if (p0 !== 48'd20) begin
        bad++; $display("FAIL cep_hold%0d: got p=%h, expected 20 (hex 14)", i, p0);
      end
    end
    cep = 1'b1; tick();
    total++;
    if (p0 !== 48'd25) begin
      bad++; $display("FAIL cep_resume: got p=%h, expected 25 (hex 19)", p0);
    end
    rst = 1'b1; tick();
    total++;
    if (p0 !== 48'd0) begin
      bad++; $display("FAIL mid_reset: got p=%h, expected 0", p0);
    end
    rst = 1'b0;
    tick();
    total++;
    if (p0 !== p_m[0]) begin
      bad++; $display("FAIL post_reset_opm: got p=%h, expected %h", p0, p_m[0]);
    end
    tick();
    total++;
    if (p0 !== 48'd5) begin
      bad++; $display("FAIL post_reset_mac: got p=%h, expected 5", p0);
    end
  endtask

  task automatic test_sub();
    opmode = 8'h8D; c = 48'd10; m = 36'd3; carryin = 1'b0;
    tick(); tick();
    total++;
    if (p0 !== 48'd7 || co0 !== 1'b0 || p1 !== 48'd7 || co1 !== 1'b0) begin
      bad++; $display("FAIL sub_plain: got p0=%h co0=%b p1=%h co1=%b, expected p=7 co=0",
                      p0, co0, p1, co1);
    end
    m = 36'd11; tick();
    total++;
    if (p0 !== 48'hFFFF_FFFF_FFFF || co0 !== 1'b1 || p1 !== 48'hFFFF_FFFF_FFFF || co1 !== 1'b1) begin
      bad++; $display("FAIL sub_borrow: got p0=%h co0=%b p1=%h co1=%b, expected p=ffffffffffff co=1",
                      p0, co0, p1, co1);
    end
  endtask

  task automatic test_overflow();
    opmode = 8'h0F; c = 48'hFFFF_FFFF_FFFF; dab = 48'd1; m = 36'd0;
    tick(); tick();
    total++;
    if (p0 !== 48'd0 || co0 !== 1'b1 || pc0 !== 48'd0) begin
      bad++; $display("FAIL add_overflow: got p=%h co=%b pcout=%h, expected p=0 co=1", p0, co0, pc0);
    end
    c = 48'd0; dab = 48'd0;
  endtask

  task automatic test_carryin();
    opmode = 8'h21; m = 36'd7; carryin = 1'b1;
    tick(); tick();
    total++;
    if (p0 !== 48'd8 || p1 !== 48'd8) begin
      bad++; $display("FAIL cin_both: got p0=%h p1=%h, expected 8", p0, p1);
    end
    opmode = 8'h01;
    tick(); tick();
    total++;
    if (p0 !== 48'd7 || p1 !== 48'd8) begin
      bad++; $display("FAIL cin_select: got p0=%h p1=%h, expected p0=7 p1=8", p0, p1);
    end
    carryin = 1'b0;
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      rst       = ($urandom_range(0, 39) == 0);
      cep       = ($urandom_range(0, 3) != 0);
      ceopmode  = ($urandom_range(0, 3) != 0);
      cecarryin = ($urandom_range(0, 3) != 0);
      carryin   = 1'($urandom());
      opmode    = 8'($urandom());
      m         = 36'({$urandom(), $urandom()});
      dab       = 48'({$urandom(), $urandom()});
      c         = 48'({$urandom(), $urandom()});
      pcin      = 48'({$urandom(), $urandom()});
      if ($urandom_range(0, 3) == 0) c = 48'hFFFF_FFFF_FFFF;
      tick();
      total++;
      if (p0 !== p_m[0] || co0 !== co_m[0] || pc0 !== p_m[0]) begin
        bad++; $display("FAIL rand_dut0[%0d]: got p=%h co=%b pcout=%h, expected p=%h co=%b",
                        i, p0, co0, pc0, p_m[0], co_m[0]);
      end
      total++;
      if (p1 !== p_m[1] || co1 !== co_m[1] || pc1 !== p_m[1]) begin
        bad++; $display("FAIL rand_dut1[%0d]: got p=%h co=%b pcout=%h, expected p=%h co=%b",
                        i, p1, co1, pc1, p_m[1], co_m[1]);
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_mac();
    test_enables();
    test_sub();
    test_overflow();
    test_carryin();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
